// File: rtl/mask_blob_if.sv
// -----------------------------------------------------------------------------
// mask_blob_if
// Bundle between the colour-mask producer and the blob tracker.
//   master : drives pixel_in / in_ready / frame_sync, observes the results
//   slave  : consumes the mask stream, drives the per-frame results
// Signals
//   pixel_in[3:0]   mask pixel, set when bit 3 is high
//   in_ready        one pixel beat this cycle (raster order)
//   frame_sync      restart frame at (0,0); same-cycle beat is pixel (0,0)
//   result_valid    one-cycle pulse, all result fields updated this cycle
//   found           blob large enough to be reported
//   pix_count       set pixels in the last completed frame
//   cx / cy         centroid column / row
//   x_min..y_max    bounding box (zero when the bbox option is not built)
// -----------------------------------------------------------------------------
interface mask_blob_if #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240
);
   localparam int X_W = $clog2(WIDTH);
   localparam int Y_W = $clog2(HEIGHT);
   localparam int C_W = $clog2(WIDTH * HEIGHT + 1);

   logic [3:0]     pixel_in;
   logic           in_ready;
   logic           frame_sync;
   logic           result_valid;
   logic           found;
   logic [C_W-1:0] pix_count;
   logic [X_W-1:0] cx;
   logic [Y_W-1:0] cy;
   logic [X_W-1:0] x_min;
   logic [X_W-1:0] x_max;
   logic [Y_W-1:0] y_min;
   logic [Y_W-1:0] y_max;

   modport master (
      output pixel_in, in_ready, frame_sync,
      input  result_valid, found, pix_count, cx, cy, x_min, x_max, y_min, y_max
   );

   modport slave (
      input  pixel_in, in_ready, frame_sync,
      output result_valid, found, pix_count, cx, cy, x_min, x_max, y_min, y_max
   );
endinterface

// File: rtl/mask_blob_tracker.sv
// -----------------------------------------------------------------------------
// mask_blob_tracker
// Follows the raster position of a binary mask stream, accumulates the set
// pixel count and x/y coordinate sums per frame, and at each frame end hands a
// snapshot to a sequential restoring divider that publishes the blob centroid.
// The next frame keeps accumulating while the divider runs.
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    mask_blob_if.slave (mask stream in, centroid results out)
// Optional build macro
//   MASK_BLOB_BBOX_EN : builds the live/shadow bounding-box trackers and
//                       publishes x_min/x_max/y_min/y_max; otherwise tied to 0.
// Result latency: result_valid pulses 2*Q_W+1 cycles after the frame-end beat.
// -----------------------------------------------------------------------------
module mask_blob_tracker #(
   parameter int WIDTH     = 320,
   parameter int HEIGHT    = 240,
   parameter int MIN_COUNT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   mask_blob_if.slave  bus
);
   localparam int X_W  = $clog2(WIDTH);
   localparam int Y_W  = $clog2(HEIGHT);
   localparam int C_W  = $clog2(WIDTH * HEIGHT + 1);
   localparam int Q_W  = (X_W > Y_W) ? X_W : Y_W;
   localparam int SX_W = C_W + X_W;
   localparam int SY_W = C_W + Y_W;
   localparam int R_W  = C_W + Q_W;
   localparam int S_W  = $clog2(Q_W + 1);

   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DIV_X = 2'd1;
   localparam logic [1:0] S_DIV_Y = 2'd2;
   localparam logic [1:0] S_PUB   = 2'd3;

   // The divider must be idle again before the next frame end can arrive.
   generate
      if (WIDTH < 2 || HEIGHT < 2 || MIN_COUNT < 1 || WIDTH * HEIGHT < 2 * Q_W + 2) begin : g_cfg_err
         $error("mask_blob_tracker: invalid WIDTH/HEIGHT/MIN_COUNT configuration");
      end
   endgenerate

   // live raster / accumulator state
   logic [X_W-1:0]  r_x;
   logic [Y_W-1:0]  r_y;
   logic [C_W-1:0]  r_cnt;
   logic [SX_W-1:0] r_sx;
   logic [SY_W-1:0] r_sy;

   // control
   logic [1:0]      r_state;
   logic [S_W-1:0]  r_step;

   // frame snapshot and divider datapath
   logic [C_W-1:0]  r_sh_cnt;
   logic [SY_W-1:0] r_sh_sy;
   logic            r_sh_found;
   logic [C_W-1:0]  r_div;
   logic [R_W-1:0]  r_rem;
   logic [R_W-1:0]  r_dsh;
   logic [Q_W-1:0]  r_q;
   logic [Q_W-1:0]  r_qx;

   // published results
   logic            r_found;
   logic [C_W-1:0]  r_pix;
   logic [X_W-1:0]  r_cx;
   logic [Y_W-1:0]  r_cy;

   logic            w_beat, w_sync, w_set, w_add, w_fend, w_pub;
   logic [X_W-1:0]  w_bx, w_nx;
   logic [Y_W-1:0]  w_by, w_ny;
   logic [C_W-1:0]  w_bcnt, w_ncnt, w_div0;
   logic [SX_W-1:0] w_bsx, w_nsx;
   logic [SY_W-1:0] w_bsy, w_nsy;
   logic            w_ge;
   logic [R_W-1:0]  w_rem_next;
   logic [Q_W-1:0]  w_q_next;
   logic            w_unused_pix;

   assign w_beat       = bus.in_ready;
   assign w_sync       = bus.frame_sync;
   assign w_set        = bus.pixel_in[3];
   assign w_unused_pix = ^bus.pixel_in[2:0];

   // frame_sync wins over a coincident frame end: the partial frame is dropped
   assign w_fend = w_beat & ~w_sync & (r_x == X_LAST) & (r_y == Y_LAST);
   assign w_pub  = (r_state == S_DIV_Y) && (r_step == S_W'(0));

   // Raster/accumulator next state; frame_sync rebases everything to an empty
   // frame at (0,0) before the same-cycle beat is applied.
   always_comb begin
      w_bx   = w_sync ? '0 : r_x;
      w_by   = w_sync ? '0 : r_y;
      w_bcnt = w_sync ? '0 : r_cnt;
      w_bsx  = w_sync ? '0 : r_sx;
      w_bsy  = w_sync ? '0 : r_sy;
      w_add  = w_beat & w_set;
      w_ncnt = w_bcnt + C_W'(w_add);
      w_nsx  = w_bsx + (w_add ? SX_W'(w_bx) : '0);
      w_nsy  = w_bsy + (w_add ? SY_W'(w_by) : '0);
      w_nx   = w_bx;
      w_ny   = w_by;
      if (w_beat) begin
         if (w_bx == X_LAST) begin
            w_nx = '0;
            w_ny = (w_by == Y_LAST) ? '0 : w_by + 1'b1;
         end else begin
            w_nx = w_bx + 1'b1;
         end
      end
      w_div0 = (w_ncnt == '0) ? C_W'(1) : w_ncnt;
   end

   // One restoring step: compare against the divisor pre-shifted to the
   // current quotient bit, so no partial-remainder shifting is needed.
   always_comb begin
      w_ge       = (r_rem >= r_dsh);
      w_rem_next = w_ge ? (r_rem - r_dsh) : r_rem;
      w_q_next   = (r_q << 1) | Q_W'(w_ge);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_cnt   <= '0;
         r_sx    <= '0;
         r_sy    <= '0;
         r_state <= S_IDLE;
         r_step  <= '0;
         r_found <= 1'b0;
         r_pix   <= '0;
         r_cx    <= '0;
         r_cy    <= '0;
      end else begin
         r_x <= w_nx;
         r_y <= w_ny;
         if (w_fend) begin
            r_cnt <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
         end else begin
            r_cnt <= w_ncnt;
            r_sx  <= w_nsx;
            r_sy  <= w_nsy;
         end
         case (r_state)
            S_IDLE: begin
               if (w_fend) begin
                  r_state <= S_DIV_X;
                  r_step  <= S_W'(Q_W - 1);
               end
            end
            S_DIV_X: begin
               if (r_step == S_W'(0)) begin
                  r_state <= S_DIV_Y;
                  r_step  <= S_W'(Q_W - 1);
               end else begin
                  r_step <= r_step - 1'b1;
               end
            end
            S_DIV_Y: begin
               if (w_pub) begin
                  r_state <= S_PUB;
                  r_pix   <= r_sh_cnt;
                  r_found <= r_sh_found;
                  r_cx    <= r_sh_found ? X_W'(r_qx) : '0;
                  r_cy    <= r_sh_found ? Y_W'(w_q_next) : '0;
               end else begin
                  r_step <= r_step - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Snapshot on frame end, then Q_W steps for x followed by Q_W steps for y.
   always_ff @(posedge clk) begin
      if (w_fend) begin
         r_sh_cnt   <= w_ncnt;
         r_sh_sy    <= w_nsy;
         r_sh_found <= (w_ncnt >= C_W'(MIN_COUNT));
         r_div      <= w_div0;
         r_rem      <= R_W'(w_nsx);
         r_dsh      <= R_W'(w_div0) << (Q_W - 1);
         r_q        <= '0;
      end else if (r_state == S_DIV_X && r_step == S_W'(0)) begin
         r_qx  <= w_q_next;
         r_rem <= R_W'(r_sh_sy);
         r_dsh <= R_W'(r_div) << (Q_W - 1);
         r_q   <= '0;
      end else if (r_state == S_DIV_X || r_state == S_DIV_Y) begin
         r_rem <= w_rem_next;
         r_dsh <= r_dsh >> 1;
         r_q   <= w_q_next;
      end
   end

   assign bus.result_valid = (r_state == S_PUB);
   assign bus.found        = r_found;
   assign bus.pix_count    = r_pix;
   assign bus.cx           = r_cx;
   assign bus.cy           = r_cy;

`ifdef MASK_BLOB_BBOX_EN
   logic [X_W-1:0] r_xmin, r_xmax, r_sh_xmin, r_sh_xmax, r_oxmin, r_oxmax;
   logic [Y_W-1:0] r_ymin, r_ymax, r_sh_ymin, r_sh_ymax, r_oymin, r_oymax;
   logic [X_W-1:0] w_bxmin, w_bxmax, w_nxmin, w_nxmax;
   logic [Y_W-1:0] w_bymin, w_bymax, w_nymin, w_nymax;

   // Empty-frame values are inverted (min=last, max=0) so the first set
   // pixel lands on both bounds.
   always_comb begin
      w_bxmin = w_sync ? X_LAST : r_xmin;
      w_bxmax = w_sync ? '0     : r_xmax;
      w_bymin = w_sync ? Y_LAST : r_ymin;
      w_bymax = w_sync ? '0     : r_ymax;
      w_nxmin = (w_add && w_bx < w_bxmin) ? w_bx : w_bxmin;
      w_nxmax = (w_add && w_bx > w_bxmax) ? w_bx : w_bxmax;
      w_nymin = (w_add && w_by < w_bymin) ? w_by : w_bymin;
      w_nymax = (w_add && w_by > w_bymax) ? w_by : w_bymax;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xmin  <= X_LAST;
         r_xmax  <= '0;
         r_ymin  <= Y_LAST;
         r_ymax  <= '0;
         r_oxmin <= '0;
         r_oxmax <= '0;
         r_oymin <= '0;
         r_oymax <= '0;
      end else begin
         if (w_fend) begin
            r_xmin <= X_LAST;
            r_xmax <= '0;
            r_ymin <= Y_LAST;
            r_ymax <= '0;
         end else begin
            r_xmin <= w_nxmin;
            r_xmax <= w_nxmax;
            r_ymin <= w_nymin;
            r_ymax <= w_nymax;
         end
         if (w_pub) begin
            r_oxmin <= r_sh_found ? r_sh_xmin : '0;
            r_oxmax <= r_sh_found ? r_sh_xmax : '0;
            r_oymin <= r_sh_found ? r_sh_ymin : '0;
            r_oymax <= r_sh_found ? r_sh_ymax : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fend) begin
         r_sh_xmin <= w_nxmin;
         r_sh_xmax <= w_nxmax;
         r_sh_ymin <= w_nymin;
         r_sh_ymax <= w_nymax;
      end
   end

   assign bus.x_min = r_oxmin;
   assign bus.x_max = r_oxmax;
   assign bus.y_min = r_oymin;
   assign bus.y_max = r_oymax;
`else
   assign bus.x_min = '0;
   assign bus.x_max = '0;
   assign bus.y_min = '0;
   assign bus.y_max = '0;
`endif

endmodule
